// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the execute stage and the
// multiply/divide unit.
//   start  request strobe, qualified by op
//   op     0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   a, b   rs / rt operands
//   busy   operation in flight (decode stalls HI/LO users on it)
//   hi, lo architectural HI / LO
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multiply/divide unit owning the architectural HI/LO registers.
// The result of mult/multu/div/divu is computed at the accepting edge and
// parked in pending registers; it becomes architecturally visible only after
// a fixed busy window (MULT_CYCLES or DIV_CYCLES), emulating an iterative unit.
// mthi/mtlo write immediately with no busy cycles.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears all state
//   bus    mdu_if slave: start/op/a/b in, busy/hi/lo out (all registered)
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          busy_r, busy_s;
  logic [31:0]   hi_r, hi_s, lo_r, lo_s;
  logic [31:0]   pend_hi_r, pend_hi_s, pend_lo_r, pend_lo_s;
  logic          pend_wr_r, pend_wr_s;

  logic [63:0]   sprod_s, uprod_s;
  logic [31:0]   mag_a_s, mag_b_s, mq_s, mr_s, sq_s, sr_s, uq_s, ur_s;
  logic [31:0]   res_hi_s, res_lo_s;
  logic          res_wr_s, res_long_s, res_div_s;

  // Arithmetic datapath. Signed divide works on magnitudes so that
  // 0x80000000 / -1 falls out as LO=0x80000000, HI=0 without a trap case.
  always_comb begin
    sprod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    uprod_s = {32'h0, bus.a} * {32'h0, bus.b};
    mag_a_s = bus.a[31] ? (32'h0 - bus.a) : bus.a;
    mag_b_s = bus.b[31] ? (32'h0 - bus.b) : bus.b;
    if (bus.b != 32'h0) begin
      mq_s = mag_a_s / mag_b_s;
      mr_s = mag_a_s % mag_b_s;
      uq_s = bus.a / bus.b;
      ur_s = bus.a % bus.b;
    end else begin
      mq_s = 32'h0;
      mr_s = 32'h0;
      uq_s = 32'h0;
      ur_s = 32'h0;
    end
    // quotient negative when operand signs differ, remainder follows dividend
    sq_s = (bus.a[31] ^ bus.b[31]) ? (32'h0 - mq_s) : mq_s;
    sr_s = bus.a[31] ? (32'h0 - mr_s) : mr_s;
  end

  // Result selection by op; divide by zero suppresses the later commit.
  always_comb begin
    res_hi_s   = 32'h0;
    res_lo_s   = 32'h0;
    res_wr_s   = 1'b0;
    res_long_s = 1'b0;
    res_div_s  = 1'b0;
    case (bus.op)
      3'd1: begin
        {res_hi_s, res_lo_s} = sprod_s;
        res_wr_s   = 1'b1;
        res_long_s = 1'b1;
      end
      3'd2: begin
        {res_hi_s, res_lo_s} = uprod_s;
        res_wr_s   = 1'b1;
        res_long_s = 1'b1;
      end
      3'd3: begin
        res_hi_s   = sr_s;
        res_lo_s   = sq_s;
        res_wr_s   = (bus.b != 32'h0);
        res_long_s = 1'b1;
        res_div_s  = 1'b1;
      end
      3'd4: begin
        res_hi_s   = ur_s;
        res_lo_s   = uq_s;
        res_wr_s   = (bus.b != 32'h0);
        res_long_s = 1'b1;
        res_div_s  = 1'b1;
      end
      default: begin
        res_wr_s = 1'b0;
      end
    endcase
  end

  // Next-state logic: accept requests in IDLE, count down the busy window.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    busy_s    = busy_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    pend_hi_s = pend_hi_r;
    pend_lo_s = pend_lo_r;
    pend_wr_s = pend_wr_r;
    case (state_r)
      IDLE: begin
        if (bus.start && res_long_s) begin
          pend_hi_s = res_hi_s;
          pend_lo_s = res_lo_s;
          pend_wr_s = res_wr_s;
          cnt_s     = res_div_s ? DIV_LOAD : MULT_LOAD;
          busy_s    = 1'b1;
          state_s   = BUSY;
        end else if (bus.start && (bus.op == 3'd5)) begin
          hi_s = bus.a;
        end else if (bus.start && (bus.op == 3'd6)) begin
          lo_s = bus.a;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // start is ignored here; only the countdown matters
        if (cnt_r <= {{(CW-1){1'b0}}, 1'b1}) begin
          if (pend_wr_r) begin
            hi_s = pend_hi_r;
            lo_s = pend_lo_r;
          end else begin
            hi_s = hi_r;
          end
          cnt_s   = {CW{1'b0}};
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      busy_r    <= 1'b0;
      hi_r      <= 32'h0;
      lo_r      <= 32'h0;
      pend_hi_r <= 32'h0;
      pend_lo_r <= 32'h0;
      pend_wr_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      busy_r    <= busy_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
      pend_hi_r <= pend_hi_s;
      pend_lo_r <= pend_lo_s;
      pend_wr_r <= pend_wr_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
